// File: rtl/truth_table_sweeper_if.sv
// Bundle of host-side and unit-side signals of the truth-table sweeper.
// slave: the sweeper itself; master: host plus the attached expression units.
interface truth_table_sweeper_if;
  logic       start;
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic [7:0] exp_c;
  logic       drv_a;
  logic       drv_b;
  logic       drv_c;
  logic       res_a;
  logic       res_b;
  logic       res_c;
  logic       busy;
  logic       done;
  logic [7:0] tt_a;
  logic [7:0] tt_b;
  logic [7:0] tt_c;
  logic [2:0] mismatch;
  logic       pass;

  modport slave (
    input  start, exp_a, exp_b, exp_c, res_a, res_b, res_c,
    output drv_a, drv_b, drv_c, busy, done, tt_a, tt_b, tt_c, mismatch, pass
  );

  modport master (
    output start, exp_a, exp_b, exp_c, res_a, res_b, res_c,
    input  drv_a, drv_b, drv_c, busy, done, tt_a, tt_b, tt_c, mismatch, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: steps {A,B,C} through 0..7, holds each value for
// SETTLE_CYCLES cycles plus one sample cycle, captures the three unit outputs
// into 8-bit signatures and compares them against tables latched at start.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       busy_q, done_q, pass_q;
  logic [7:0] tt_a_q, tt_b_q, tt_c_q;
  logic [7:0] ea_q, eb_q, ec_q;
  logic [2:0] mm_q;

  logic       accept, sample;
  logic [7:0] tt_a_nx, tt_b_nx, tt_c_nx;
  logic [2:0] mm_nx;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode and per-cycle strobes
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    sample   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept   = 1'b1;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_nx = SAMPLE;
      end
      SAMPLE: begin
        sample   = 1'b1;
        state_nx = (idx == 3'd7) ? DONE : SETTLE;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Signatures including the bit being captured this cycle, so the final
  // comparison sees the complete table on the same edge that stores it.
  always_comb begin
    tt_a_nx      = tt_a_q;
    tt_b_nx      = tt_b_q;
    tt_c_nx      = tt_c_q;
    tt_a_nx[idx] = bus.res_a;
    tt_b_nx[idx] = bus.res_b;
    tt_c_nx[idx] = bus.res_c;
    mm_nx        = {tt_c_nx != ec_q, tt_b_nx != eb_q, tt_a_nx != ea_q};
  end

  // Datapath: expected-table latch, index/settle counter, capture and results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tt_a_q <= '0;
      tt_b_q <= '0;
      tt_c_q <= '0;
      ea_q   <= '0;
      eb_q   <= '0;
      ec_q   <= '0;
      mm_q   <= '0;
    end else begin
      if (accept) begin
        ea_q   <= bus.exp_a;
        eb_q   <= bus.exp_b;
        ec_q   <= bus.exp_c;
        tt_a_q <= '0;
        tt_b_q <= '0;
        tt_c_q <= '0;
        mm_q   <= '0;
        pass_q <= 1'b0;
        idx    <= '0;
        cnt    <= CNT_LOAD;
        busy_q <= 1'b1;
      end
      if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (sample) begin
        tt_a_q <= tt_a_nx;
        tt_b_q <= tt_b_nx;
        tt_c_q <= tt_c_nx;
        if (idx != 3'd7) begin
          idx <= idx + 3'd1;
          cnt <= CNT_LOAD;
        end else begin
          mm_q   <= mm_nx;
          pass_q <= ~|mm_nx;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
      if (state == DONE) done_q <= 1'b0;
    end
  end

  // The drive register and the index are the same value: drv equals idx
  // while busy and both hold afterwards.
  assign bus.drv_a    = idx[2];
  assign bus.drv_b    = idx[1];
  assign bus.drv_c    = idx[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tt_a     = tt_a_q;
  assign bus.tt_b     = tt_b_q;
  assign bus.tt_c     = tt_c_q;
  assign bus.mismatch = mm_q;
  assign bus.pass     = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: table-lookup units (combinational or with a
// registered delay), scenario tasks with inline checks, random sweeps.
module tb_truth_table_sweeper;

  localparam int S0 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] fn_a, fn_b, fn_c;  // unit functions as truth tables
  logic       delayed;           // dut0 units use the delayed model
  int         done1_cnt = 0;

  truth_table_sweeper_if if0();
  truth_table_sweeper_if if1();

  truth_table_sweeper #(.SETTLE_CYCLES(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  truth_table_sweeper #(.SETTLE_CYCLES(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [2:0] i0, i1;
  assign i0 = {if0.drv_a, if0.drv_b, if0.drv_c};
  assign i1 = {if1.drv_a, if1.drv_b, if1.drv_c};

  // Delay model: output appears three cycles after the drive edge
  // (drive register plus two stages), so it is visible to a sample taken
  // SETTLE_CYCLES+1 = 3 cycles later but not to one taken 2 cycles later.
  logic [2:0] d0_s1, d0_s2, d1_s1, d1_s2;
  always @(posedge clk) begin
    d0_s1 <= {fn_a[i0], fn_b[i0], fn_c[i0]};
    d0_s2 <= d0_s1;
    d1_s1 <= {fn_a[i1], fn_b[i1], fn_c[i1]};
    d1_s2 <= d1_s1;
    if (if1.done) done1_cnt <= done1_cnt + 1;
  end

  assign if0.res_a = delayed ? d0_s2[2] : fn_a[i0];
  assign if0.res_b = delayed ? d0_s2[1] : fn_b[i0];
  assign if0.res_c = delayed ? d0_s2[0] : fn_c[i0];
  assign if1.res_a = d1_s2[2];
  assign if1.res_b = d1_s2[1];
  assign if1.res_c = d1_s2[0];

  // Pulses start on both DUTs and observes dut0 for a bounded window.
  // j = number of edges after the start-accept edge.
  task automatic do_sweep(input int restart_at, input int exp_at,
                          output int done_j, output int done_cnt,
                          output int busy_cnt, output int drv_bad);
    @(negedge clk);
    if0.start = 1'b1;
    if1.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
    done_j = -1; done_cnt = 0; busy_cnt = 0; drv_bad = 0;
    for (int j = 0; j < 8 * (S0 + 1) + 6; j++) begin
      if (j > 0) @(negedge clk);
      if (if0.busy) begin
        busy_cnt++;
        if (i0 !== 3'(j / (S0 + 1))) drv_bad++;
      end
      if (if0.done) begin
        done_cnt++;
        if (done_j < 0) done_j = j;
      end
      if0.start = (j == restart_at);
      if (j == exp_at) if0.exp_a = 8'h00;
    end
    if0.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    if0.start = 1'b1;
    if1.start = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (i0 !== 3'b000) begin bad++; $display("FAIL reset_drv got=%b want=000", i0); end
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", if0.busy); end
    total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", if0.done); end
    total++; if (if0.tt_a !== 8'h00) begin bad++; $display("FAIL reset_tt_a got=%h want=00", if0.tt_a); end
    total++; if (if0.tt_b !== 8'h00) begin bad++; $display("FAIL reset_tt_b got=%h want=00", if0.tt_b); end
    total++; if (if0.tt_c !== 8'h00) begin bad++; $display("FAIL reset_tt_c got=%h want=00", if0.tt_c); end
    total++; if (if0.mismatch !== 3'b000) begin bad++; $display("FAIL reset_mismatch got=%b want=000", if0.mismatch); end
    total++; if (if0.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b want=0", if0.pass); end
    if0.start = 1'b0;
    if1.start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL reset_no_sweep busy got=%b want=0", if0.busy); end
  endtask

  task automatic test_nominal;
    int dj, dc, bc, db;
    fn_a = 8'h6E; fn_b = 8'h7B; fn_c = 8'hDB;
    if0.exp_a = 8'h6E; if0.exp_b = 8'h7B; if0.exp_c = 8'hDB;
    do_sweep(-1, -1, dj, dc, bc, db);
    total++; if (dj !== 8 * (S0 + 1)) begin bad++; $display("FAIL nom_done_time got=%0d want=%0d", dj, 8 * (S0 + 1)); end
    total++; if (dc !== 1) begin bad++; $display("FAIL nom_done_pulses got=%0d want=1", dc); end
    total++; if (bc !== 8 * (S0 + 1)) begin bad++; $display("FAIL nom_busy_cycles got=%0d want=%0d", bc, 8 * (S0 + 1)); end
    total++; if (db !== 0) begin bad++; $display("FAIL nom_drv_seq bad_cycles got=%0d want=0", db); end
    total++; if (i0 !== 3'b111) begin bad++; $display("FAIL nom_drv_hold got=%b want=111", i0); end
    total++; if (if0.tt_a !== 8'h6E) begin bad++; $display("FAIL nom_tt_a got=%h want=6e", if0.tt_a); end
    total++; if (if0.tt_b !== 8'h7B) begin bad++; $display("FAIL nom_tt_b got=%h want=7b", if0.tt_b); end
    total++; if (if0.tt_c !== 8'hDB) begin bad++; $display("FAIL nom_tt_c got=%h want=db", if0.tt_c); end
    total++; if (if0.mismatch !== 3'b000) begin bad++; $display("FAIL nom_mismatch got=%b want=000", if0.mismatch); end
    total++; if (if0.pass !== 1'b1) begin bad++; $display("FAIL nom_pass got=%b want=1", if0.pass); end
  endtask

  task automatic test_fault;
    int dj, dc, bc, db;
    if0.exp_b = 8'h7A;
    do_sweep(-1, -1, dj, dc, bc, db);
    total++; if (dc !== 1) begin bad++; $display("FAIL fault_done_pulses got=%0d want=1", dc); end
    total++; if (if0.tt_a !== 8'h6E) begin bad++; $display("FAIL fault_tt_a got=%h want=6e", if0.tt_a); end
    total++; if (if0.tt_b !== 8'h7B) begin bad++; $display("FAIL fault_tt_b got=%h want=7b", if0.tt_b); end
    total++; if (if0.tt_c !== 8'hDB) begin bad++; $display("FAIL fault_tt_c got=%h want=db", if0.tt_c); end
    total++; if (if0.mismatch !== 3'b010) begin bad++; $display("FAIL fault_mismatch got=%b want=010", if0.mismatch); end
    total++; if (if0.pass !== 1'b0) begin bad++; $display("FAIL fault_pass got=%b want=0", if0.pass); end
    if0.exp_b = 8'h7B;
  endtask

  task automatic test_ignore;
    int dj, dc, bc, db;
    if0.exp_a = 8'h6E;
    do_sweep(10, 5, dj, dc, bc, db);
    total++; if (dc !== 1) begin bad++; $display("FAIL ign_done_pulses got=%0d want=1", dc); end
    total++; if (dj !== 8 * (S0 + 1)) begin bad++; $display("FAIL ign_done_time got=%0d want=%0d", dj, 8 * (S0 + 1)); end
    total++; if (db !== 0) begin bad++; $display("FAIL ign_drv_seq bad_cycles got=%0d want=0", db); end
    total++; if (if0.mismatch !== 3'b000) begin bad++; $display("FAIL ign_mismatch got=%b want=000", if0.mismatch); end
    total++; if (if0.pass !== 1'b1) begin bad++; $display("FAIL ign_pass got=%b want=1", if0.pass); end
    if0.exp_a = 8'h6E;
  endtask

  task automatic test_reset_mid;
    int dj, dc, bc, db;
    @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (13) @(negedge clk);  // j = 13: index 4 is being driven
    total++; if (i0 !== 3'd4) begin bad++; $display("FAIL mid_drv_before got=%0d want=4", i0); end
    rst_n = 1'b0;
    #1;
    total++; if (if0.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", if0.busy); end
    total++; if (if0.tt_a !== 8'h00) begin bad++; $display("FAIL mid_tt_a got=%h want=00", if0.tt_a); end
    total++; if (if0.tt_b !== 8'h00) begin bad++; $display("FAIL mid_tt_b got=%h want=00", if0.tt_b); end
    total++; if (i0 !== 3'b000) begin bad++; $display("FAIL mid_drv got=%b want=000", i0); end
    @(negedge clk);
    rst_n = 1'b1;
    do_sweep(-1, -1, dj, dc, bc, db);
    total++; if (dj !== 8 * (S0 + 1)) begin bad++; $display("FAIL mid_resweep_time got=%0d want=%0d", dj, 8 * (S0 + 1)); end
    total++; if (if0.tt_c !== 8'hDB) begin bad++; $display("FAIL mid_resweep_tt_c got=%h want=db", if0.tt_c); end
    total++; if (if0.pass !== 1'b1) begin bad++; $display("FAIL mid_resweep_pass got=%b want=1", if0.pass); end
  endtask

  task automatic test_settle_margin;
    int dj, dc, bc, db;
    int d1_before;
    delayed = 1'b1;
    if1.exp_a = 8'h6E; if1.exp_b = 8'h7B; if1.exp_c = 8'hDB;
    d1_before = done1_cnt;
    do_sweep(-1, -1, dj, dc, bc, db);
    total++; if (if0.pass !== 1'b1) begin bad++; $display("FAIL settle2_pass got=%b want=1", if0.pass); end
    total++; if (if0.tt_a !== 8'h6E) begin bad++; $display("FAIL settle2_tt_a got=%h want=6e", if0.tt_a); end
    total++; if (done1_cnt - d1_before !== 1) begin bad++; $display("FAIL settle1_done got=%0d want=1", done1_cnt - d1_before); end
    total++; if (if1.mismatch === 3'b000) begin bad++; $display("FAIL settle1_mismatch got=%b want=nonzero", if1.mismatch); end
    total++; if (if1.pass !== 1'b0) begin bad++; $display("FAIL settle1_pass got=%b want=0", if1.pass); end
    delayed = 1'b0;
  endtask

  // Random unit functions and expected tables; the model is just the rule
  // "signature = the unit's truth table, mismatch = per-unit inequality".
  task automatic test_random;
    int dj, dc, bc, db;
    logic [2:0] want_mm;
    for (int n = 0; n < 8; n++) begin
      fn_a = 8'($urandom); fn_b = 8'($urandom); fn_c = 8'($urandom);
      if0.exp_a = ($urandom_range(0, 1) == 0) ? fn_a : fn_a ^ 8'(1 << $urandom_range(0, 7));
      if0.exp_b = ($urandom_range(0, 1) == 0) ? fn_b : fn_b ^ 8'(1 << $urandom_range(0, 7));
      if0.exp_c = ($urandom_range(0, 1) == 0) ? fn_c : fn_c ^ 8'(1 << $urandom_range(0, 7));
      want_mm = {fn_c != if0.exp_c, fn_b != if0.exp_b, fn_a != if0.exp_a};
      do_sweep(-1, -1, dj, dc, bc, db);
      total++; if (dj !== 8 * (S0 + 1)) begin bad++; $display("FAIL rnd%0d_done_time got=%0d want=%0d", n, dj, 8 * (S0 + 1)); end
      total++; if ({if0.tt_a, if0.tt_b, if0.tt_c} !== {fn_a, fn_b, fn_c}) begin
        bad++; $display("FAIL rnd%0d_tt got=%h/%h/%h want=%h/%h/%h", n, if0.tt_a, if0.tt_b, if0.tt_c, fn_a, fn_b, fn_c);
      end
      total++; if (if0.mismatch !== want_mm) begin bad++; $display("FAIL rnd%0d_mismatch got=%b want=%b", n, if0.mismatch, want_mm); end
      total++; if (if0.pass !== (want_mm == 3'b000)) begin bad++; $display("FAIL rnd%0d_pass got=%b want=%b", n, if0.pass, want_mm == 3'b000); end
    end
  endtask

  initial begin
    delayed = 1'b0;
    fn_a = 8'h6E; fn_b = 8'h7B; fn_c = 8'hDB;
    if0.start = 1'b0; if0.exp_a = '0; if0.exp_b = '0; if0.exp_c = '0;
    if1.start = 1'b0; if1.exp_a = '0; if1.exp_b = '0; if1.exp_c = '0;
    test_reset;
    test_nominal;
    test_fault;
    test_ignore;
    test_reset_mid;
    test_settle_margin;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that exhaustively drives the three 3-input Boolean expression units (subpoint A, subpoint B, custom expression) through all 8 input combinations.
- Captures each unit's output into an 8-bit truth-table signature and compares the three signatures against expected values latched at start.
- Reports pass/fail per function.
- Sits between a test/control host and the combinational NAND-built expression units, replacing the hand-written stimulus sweep.

Parameters:
- SETTLE_CYCLES, default 2: cycles the inputs are held before the sample cycle; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  sweep request; sampled only in IDLE
- exp_a  input  8  expected truth table, subpoint A unit; bit i = output for {A,B,C}=i
- exp_b  input  8  expected truth table, subpoint B unit
- exp_c  input  8  expected truth table, custom expression unit
- drv_a  output  1  A input to all three units (MSB of index)
- drv_b  output  1  B input to all three units
- drv_c  output  1  C input to all three units (LSB of index)
- res_a  input  1  subpoint A unit output
- res_b  input  1  subpoint B unit output
- res_c  input  1  custom unit output
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse when sweep completes
- tt_a  output  8  captured truth table, subpoint A unit
- tt_b  output  8  captured truth table, subpoint B unit
- tt_c  output  8  captured truth table, custom unit
- mismatch  output  3  {c,b,a}: bit set if captured table differs from expected
- pass  output  1  high when mismatch==000 after a completed sweep

Behaviour:
- Reset (async, rst_n low): state=IDLE; idx=0; drv_{a,b,c}=0; busy=0; done=0; tt_*=0; mismatch=0; pass=0; latched exp=0.
- All outputs are registered. {drv_a,drv_b,drv_c} always equals idx while busy; it holds its last value otherwise.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: on start=1, latch exp_*; clear tt_*, mismatch and pass; set idx=0 and drv=000; load cnt=SETTLE_CYCLES-1; set busy=1; go to SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles (cnt decrements; exit when cnt==0) -> SAMPLE.
- SAMPLE (1 cycle): at its closing edge, tt_a[idx]<=res_a, tt_b[idx]<=res_b, tt_c[idx]<=res_c.
  - idx<7: idx++, drv<=idx+1, reload cnt, go to SETTLE.
  - idx==7: mismatch<={tt_c!=exp_c, tt_b!=exp_b, tt_a!=exp_a}, computed using the bit just captured. pass<=~|mismatch. busy<=0, done<=1, go to DONE.
- DONE: done high for exactly one cycle, then IDLE with done=0.
- Results (tt_*, mismatch, pass) hold until the next accepted start.
- Timing: unit outputs must be valid within SETTLE_CYCLES+1 cycles of a drive change. A full sweep is 8*(SETTLE_CYCLES+1) cycles from the start-accept edge to the edge asserting done; this is 24 cycles at the default.
- start while busy or in DONE: ignored, with no restart or re-latch.
- Changes to exp_* mid-sweep are ignored; only the values latched at start are used.
- idx is 3 bits and never wraps during a sweep; the sweep ends after idx 7.
- Reset asserted mid-sweep: immediate return to reset values; the partial sweep is discarded.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> all outputs 0, drv=000, busy=0, no sweep begins until rst_n=1.
- Nominal, SETTLE_CYCLES=2, real units attached, exp_a=0x6E, exp_b=0x7B, exp_c=0xDB, pulse start -> drv steps 000..111 with each value held 3 cycles; busy high for 24 cycles; done pulses 1 cycle; tt_a=0x6E, tt_b=0x7B, tt_c=0xDB; mismatch=000; pass=1.
- Fault: same run with exp_b=0x7A -> tt_b=0x7B, mismatch=010, pass=0; tt_a and tt_c unchanged.
- Ignore rules: re-pulse start at cycle 10 of a sweep and change exp_a to 0x00 at cycle 5 -> a single done at cycle 24, pass=1, no restart.
- Reset mid-sweep: drop rst_n while idx=4 -> busy=0, tt_*=0, drv=000 immediately. A new start then completes a clean nominal sweep with pass=1.
- Settle margin: replace units with a 3-cycle registered delay model of the same functions -> SETTLE_CYCLES=2 gives pass=1; SETTLE_CYCLES=1 gives mismatch!=000, pass=0.
